// File: rtl/piano_key_arbiter_if.sv
// Key/tone bus of the piano key arbiter: raw keys and mute in, tone and status out.
interface piano_key_arbiter_if #(
    parameter int unsigned NUM_KEYS = 10
);
    logic [NUM_KEYS-1:0] keys;
    logic                mute;
    logic                piezo;
    logic                active;
    logic [3:0]          key_idx;

    modport master (
        output keys,
        output mute,
        input  piezo,
        input  active,
        input  key_idx
    );

    modport slave (
        input  keys,
        input  mute,
        output piezo,
        output active,
        output key_idx
    );
endinterface

// File: rtl/piano_key_arbiter.sv
// Single-voice note scheduler: debounces the keys, keeps a press-order stack
// (newest on top), and sequences one shared tone generator through a silent
// gap whenever the sounding note changes.
module piano_key_arbiter #(
    parameter int unsigned NUM_KEYS   = 10,
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned GAP_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    piano_key_arbiter_if.slave bus
);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned SW = $clog2(NUM_KEYS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    logic [NUM_KEYS-1:0] s1, s2, deb, deb_nxt;
    logic [DW-1:0]       dcnt [NUM_KEYS];
    logic [3:0]          stk [NUM_KEYS];
    logic [3:0]          stk_nxt [NUM_KEYS];
    logic [SW-1:0]       depth, depth_nxt;
    logic                win_v;
    logic [3:0]          win;

    state_t              state;
    logic [11:0]         tcnt;
    logic [11:0]         half;
    logic [GW-1:0]       gcnt;
    logic                tone;
    logic                piezo_r, active_r;
    logic [3:0]          key_idx_r;

    assign bus.piezo   = piezo_r;
    assign bus.active  = active_r;
    assign bus.key_idx = key_idx_r;

    // Debounced level for this cycle: flips once the synced level has differed for DEB_CYCLES clks.
    always_comb begin
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            deb_nxt[k] = deb[k];
            if ((s2[k] != deb[k]) && (dcnt[k] == DEB_LAST)) begin
                deb_nxt[k] = ~deb[k];
            end
        end
    end

    // Two-flop synchronizers and per-key debounce counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                dcnt[k] <= '0;
            end
        end else begin
            s1  <= bus.keys;
            s2  <= s1;
            deb <= deb_nxt;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if ((s2[k] == deb[k]) || (dcnt[k] == DEB_LAST)) begin
                    dcnt[k] <= '0;
                end else begin
                    dcnt[k] <= dcnt[k] + 1'b1;
                end
            end
        end
    end

    // Next press-order stack: drop released keys keeping order, then push new presses
    // in ascending index so the highest same-cycle press lands on top. The winner is
    // taken from this next-state stack so the FSM reacts in the same clk the debounce flips.
    always_comb begin
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            stk_nxt[i] = '0;
        end
        depth_nxt = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if ((SW'(i) < depth) && deb_nxt[stk[i]]) begin
                stk_nxt[depth_nxt] = stk[i];
                depth_nxt          = depth_nxt + 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (deb_nxt[k] && !deb[k]) begin
                stk_nxt[depth_nxt] = 4'(k);
                depth_nxt          = depth_nxt + 1'b1;
            end
        end
        win_v = (depth_nxt != '0);
        win   = win_v ? stk_nxt[depth_nxt - 1'b1] : '0;
    end

    // Press-order stack registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                stk[i] <= '0;
            end
        end else begin
            depth <= depth_nxt;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                stk[i] <= stk_nxt[i];
            end
        end
    end

    // Half-period of the sounding note, in clk cycles.
    always_comb begin
        case (key_idx_r)
            4'd0:    half = 12'd1516;
            4'd1:    half = 12'd3822;
            4'd2:    half = 12'd3405;
            4'd3:    half = 12'd3033;
            4'd4:    half = 12'd2863;
            4'd5:    half = 12'd2551;
            4'd6:    half = 12'd2272;
            4'd7:    half = 12'd2024;
            4'd8:    half = 12'd1911;
            4'd9:    half = 12'd1702;
            default: half = 12'd1516;
        endcase
    end

    // Note sequencer with tone generator; mute gates only the registered piezo output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            gcnt      <= '0;
            tone      <= 1'b0;
            piezo_r   <= 1'b0;
            active_r  <= 1'b0;
            key_idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tone    <= 1'b0;
                    piezo_r <= 1'b0;
                    tcnt    <= '0;
                    if (win_v) begin
                        state     <= PLAY;
                        key_idx_r <= win;
                        active_r  <= 1'b1;
                    end else begin
                        active_r  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (!win_v) begin
                        state    <= IDLE;
                        active_r <= 1'b0;
                        tone     <= 1'b0;
                        piezo_r  <= 1'b0;
                        tcnt     <= '0;
                    end else if (win != key_idx_r) begin
                        state    <= GAP;
                        active_r <= 1'b0;
                        tone     <= 1'b0;
                        piezo_r  <= 1'b0;
                        tcnt     <= '0;
                        gcnt     <= '0;
                    end else if (tcnt == half - 12'd1) begin
                        tcnt    <= '0;
                        tone    <= ~tone;
                        piezo_r <= ~tone & ~bus.mute;
                    end else begin
                        tcnt    <= tcnt + 12'd1;
                        piezo_r <= tone & ~bus.mute;
                    end
                end
                GAP: begin
                    tone    <= 1'b0;
                    piezo_r <= 1'b0;
                    tcnt    <= '0;
                    if (gcnt == GAP_LAST) begin
                        gcnt <= '0;
                        if (win_v) begin
                            state     <= PLAY;
                            key_idx_r <= win;
                            active_r  <= 1'b1;
                        end else begin
                            state     <= IDLE;
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    active_r <= 1'b0;
                    tone     <= 1'b0;
                    piezo_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piano_key_arbiter.sv
// Bench for piano_key_arbiter (DEB_CYCLES=4, GAP_CYCLES=8): stimulus pushes the
// expected note entries; a monitor pops one at every rising edge of active.
module tb_piano_key_arbiter;
    localparam int NK = 10;

    typedef struct {
        int key;   // expected key_idx on entering PLAY
        int lat;   // clks from the marked stimulus edit to active rising
        int gap;   // expected silent clks before this note, -1 = not checked
        int half;  // expected half period, 0 = not measured
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    piano_key_arbiter_if #(.NUM_KEYS(NK)) bus ();

    piano_key_arbiter #(
        .NUM_KEYS  (NK),
        .DEB_CYCLES(4),
        .GAP_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   mark = 0;
    int   total = 0;
    int   passed = 0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic push(input int key, input int lat, input int gap, input int half);
        exp_t e;
        e.key = key; e.lat = lat; e.gap = gap; e.half = half;
        sbq.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_piezo(input int lim, output int got);
        got = 0;
        for (int i = 0; i < lim && got == 0; i++) begin
            @(negedge clk);
            if (bus.piezo) got = 1;
        end
    endtask

    // Monitor: checks note entries, gap length, first tone edge and period.
    initial begin
        exp_t cur;
        logic pa, pp;
        bit   meas;
        int   off_cyc, on_cyc, first_cyc, rises;
        pa = 1'b0; pp = 1'b0; meas = 0;
        off_cyc = 0; on_cyc = 0; first_cyc = 0; rises = 0;
        cur.key = 0; cur.lat = 0; cur.gap = -1; cur.half = 0;
        forever begin
            @(negedge clk);
            if (bus.active && !pa) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL sb_on: unexpected note key_idx=%0d, required no note", bus.key_idx);
                end else begin
                    cur = sbq.pop_front();
                    chk("on_key_idx", int'(bus.key_idx), cur.key);
                    chk("on_latency", cyc - mark, cur.lat);
                    if (cur.gap >= 0) chk("gap_len", cyc - off_cyc, cur.gap);
                    meas   = (cur.half != 0);
                    rises  = 0;
                    on_cyc = cyc;
                end
            end
            if (!bus.active && pa) begin
                off_cyc = cyc;
                if (meas) begin
                    total++;
                    $display("FAIL period_cut: note ended after %0d rises, required 2", rises);
                    meas = 0;
                end
            end
            if (meas && bus.piezo && !pp) begin
                rises++;
                if (rises == 1) begin
                    chk("first_rise", cyc - on_cyc, cur.half);
                    first_cyc = cyc;
                end else begin
                    chk("period", cyc - first_cyc, 2 * cur.half);
                    meas = 0;
                end
            end
            pa = bus.active;
            pp = bus.piezo;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int got, hi;
        bus.keys = '0;
        bus.mute = 1'b0;

        // 1: reset state and quiet IDLE after release
        wait_cyc(3);
        chk("rst_piezo", int'(bus.piezo), 0);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_key_idx", int'(bus.key_idx), 0);
        rst = 1'b1;
        wait_cyc(10);
        chk("idle_active", int'(bus.active), 0);
        chk("idle_piezo", int'(bus.piezo), 0);

        // 2: clean press of key 1
        bus.keys[1] = 1'b1; mark = cyc;
        push(1, 6, -1, 3822);
        wait_cyc(11600);

        // 3: key 9 over key 1, then fall back to key 1
        bus.keys[9] = 1'b1; mark = cyc;
        push(9, 14, 8, 1702);
        wait_cyc(5200);
        bus.keys[9] = 1'b0; mark = cyc;
        push(1, 14, 8, 3822);
        wait_cyc(11600);
        bus.keys[1] = 1'b0;
        wait_cyc(12);
        chk("rel1_active", int'(bus.active), 0);
        chk("rel1_piezo", int'(bus.piezo), 0);
        chk("rel1_key_idx_hold", int'(bus.key_idx), 1);

        // 4: bouncing key 3, then steady
        for (int i = 0; i < 10; i++) begin
            bus.keys[3] = 1'b1; wait_cyc(2);
            bus.keys[3] = 1'b0; wait_cyc(2);
        end
        chk("bounce_silent", int'(bus.active), 0);
        bus.keys[3] = 1'b1; mark = cyc;
        push(3, 6, -1, 0);
        wait_cyc(20);
        chk("bounce_play", int'(bus.active), 1);
        bus.keys[3] = 1'b0;
        wait_cyc(12);
        chk("rel3_active", int'(bus.active), 0);
        chk("rel3_key_idx_hold", int'(bus.key_idx), 3);

        // 5: keys 4 and 6 together, mute, then fall back to key 4
        bus.keys[4] = 1'b1; bus.keys[6] = 1'b1; mark = cyc;
        push(6, 6, -1, 2272);
        wait_cyc(7000);
        bus.mute = 1'b1;
        wait_cyc(2);
        hi = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.piezo) hi = 1;
        end
        chk("mute_piezo_low", hi, 0);
        chk("mute_active", int'(bus.active), 1);
        bus.mute = 1'b0;
        wait_piezo(5000, got);
        chk("unmute_resume", got, 1);
        bus.keys[6] = 1'b0; mark = cyc;
        push(4, 14, 8, 0);
        wait_cyc(30);
        chk("fallback_key_idx", int'(bus.key_idx), 4);
        bus.keys[4] = 1'b0;
        wait_cyc(12);
        chk("rel4_active", int'(bus.active), 0);

        // 6: asynchronous reset in the middle of a note
        bus.keys[0] = 1'b1; mark = cyc;
        push(0, 6, -1, 0);
        wait_cyc(10);
        wait_piezo(2000, got);
        chk("pre_reset_piezo_high", got, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_piezo", int'(bus.piezo), 0);
        chk("async_rst_active", int'(bus.active), 0);
        chk("async_rst_key_idx", int'(bus.key_idx), 0);
        @(negedge clk);
        rst = 1'b1; mark = cyc;
        push(0, 6, -1, 1516);
        wait_cyc(4700);
        bus.keys[0] = 1'b0;
        wait_cyc(12);
        chk("rel0_active", int'(bus.active), 0);

        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
